// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage with forwarding, branch/jump resolve and EX/MEM register.
// `define MD_UNIT_EN to build in the iterative RV32M multiply/divide unit.
module ex_stage_md #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_e,
  input  logic            regwrite_e,
  input  logic            memwrite_e,
  input  logic            jump_e,
  input  logic            branch_e,
  input  logic            jalr_e,
  input  logic            alu_src_e,
  input  logic [1:0]      result_src_e,
  input  logic [3:0]      alu_control_e,
  input  logic [2:0]      branch_control_e,
  input  logic            md_en_e,
  input  logic [2:0]      md_op_e,
  input  logic [XLEN-1:0] rs1_data_e,
  input  logic [XLEN-1:0] rs2_data_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc_plus_4_e,
  input  logic [XLEN-1:0] immediate_e,
  input  logic [RA_W-1:0] rd_e,
  input  logic [1:0]      forward_a_e,
  input  logic [1:0]      forward_b_e,
  input  logic [XLEN-1:0] result_w,
  input  logic            flush_e,
  output logic            stall_e,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            valid_m,
  output logic            regwrite_m,
  output logic            memwrite_m,
  output logic [1:0]      result_src_m,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] writedata_m,
  output logic [XLEN-1:0] pc_plus_4_m,
  output logic [RA_W-1:0] rd_m
);
  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN + 1);

  logic [XLEN-1:0] fa, fb, src_b, alu_y, res, tgt_j;
  logic            branch_flag;

  always_comb begin
    unique case (forward_a_e)
      2'b01:   fa = result_w;
      2'b10:   fa = alu_result_m;
      default: fa = rs1_data_e;
    endcase
    unique case (forward_b_e)
      2'b01:   fb = result_w;
      2'b10:   fb = alu_result_m;
      default: fb = rs2_data_e;
    endcase
  end

  assign src_b = alu_src_e ? immediate_e : fb;

  always_comb begin
    alu_y = '0;
    unique case (alu_control_e)
      4'd0:    alu_y = fa + src_b;
      4'd1:    alu_y = fa - src_b;
      4'd2:    alu_y = fa & src_b;
      4'd3:    alu_y = fa | src_b;
      4'd4:    alu_y = fa ^ src_b;
      4'd5:    alu_y = {{(XLEN-1){1'b0}}, $signed(fa) < $signed(src_b)};
      4'd6:    alu_y = {{(XLEN-1){1'b0}}, fa < src_b};
      4'd7:    alu_y = fa << src_b[SH_W-1:0];
      4'd8:    alu_y = fa >> src_b[SH_W-1:0];
      4'd9:    alu_y = $unsigned($signed(fa) >>> src_b[SH_W-1:0]);
      4'd10:   alu_y = src_b;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    branch_flag = 1'b0;
    unique case (branch_control_e)
      3'b000:  branch_flag = fa == fb;
      3'b001:  branch_flag = fa != fb;
      3'b100:  branch_flag = $signed(fa) < $signed(fb);
      3'b101:  branch_flag = $signed(fa) >= $signed(fb);
      3'b110:  branch_flag = fa < fb;
      3'b111:  branch_flag = fa >= fb;
      default: branch_flag = 1'b0;
    endcase
  end

  assign tgt_j       = fa + immediate_e;
  assign pc_target_e = jalr_e ? {tgt_j[XLEN-1:1], 1'b0} : pc_e + immediate_e;
  assign pc_src_e    = valid_e & !flush_e & (jump_e | branch_e & branch_flag);

`ifdef MD_UNIT_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  md_state_t         state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic [XLEN-1:0]   hi, lo, opnd, abs_a, abs_b, q, r, md_y;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     sum, shl, diff;
  logic              neg, neg_n, done, start, is_div, div0, ovf, special;
  logic              signed_a, signed_b, s_a, s_b;

  assign start    = valid_e & md_en_e & !flush_e & (state == IDLE);
  assign is_div   = md_op_e[2];
  assign div0     = is_div & (fb == '0);
  assign ovf      = is_div & !md_op_e[0] & (&fb)
                  & (fa == {1'b1, {(XLEN-1){1'b0}}});
  assign special  = div0 | ovf;
  assign signed_a = (md_op_e == 3'd1) | (md_op_e == 3'd2) | (is_div & !md_op_e[0]);
  assign signed_b = (md_op_e == 3'd1) | (is_div & !md_op_e[0]);
  assign s_a      = signed_a & fa[XLEN-1];
  assign s_b      = signed_b & fb[XLEN-1];
  assign abs_a    = s_a ? -fa : fa;
  assign abs_b    = s_b ? -fb : fb;
  // remainder takes the dividend's sign, everything else the xor
  assign neg_n    = (is_div & md_op_e[1]) ? s_a : s_a ^ s_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush_e) state_n = IDLE;
    else begin
      unique case (state)
        IDLE:    if (start) state_n = special ? DONE : BUSY;
        BUSY:    if (cnt == CNT_W'(1)) state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    stall_e = start;
    done    = 1'b0;
    unique case (state)
      BUSY:    stall_e = !flush_e;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
  assign shl  = {hi, lo[XLEN-1]};
  assign diff = shl - {1'b0, opnd};

  // special cases preload hi/lo so DONE needs no separate result path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      op   <= '0;
      neg  <= 1'b0;
      hi   <= '0;
      lo   <= '0;
      opnd <= '0;
    end else if (start) begin
      cnt  <= CNT_W'(XLEN);
      op   <= md_op_e;
      neg  <= special ? 1'b0 : neg_n;
      opnd <= is_div ? abs_b : abs_a;
      if (div0) begin
        hi <= fa;
        lo <= '1;
      end else if (ovf) begin
        hi <= '0;
        lo <= fa;
      end else begin
        hi <= '0;
        lo <= is_div ? abs_a : abs_b;
      end
    end else if (state == BUSY) begin
      cnt <= cnt - CNT_W'(1);
      if (op[2]) begin
        hi <= diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
        lo <= {lo[XLEN-2:0], !diff[XLEN]};
      end else begin
        hi <= sum[XLEN:1];
        lo <= {sum[0], lo[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    prod = neg ? -{hi, lo} : {hi, lo};
    q    = neg ? -lo : lo;
    r    = neg ? -hi : hi;
    md_y = prod[2*XLEN-1:XLEN];
    unique case (1'b1)
      op[2] & op[1]:  md_y = r;
      op[2] & !op[1]: md_y = q;
      op == 3'd0:     md_y = prod[XLEN-1:0];
      default:        ;
    endcase
  end

  assign res = done ? md_y : alu_y;
`else
  logic unused_md;

  assign unused_md = ^md_op_e;
  assign stall_e   = 1'b0;
  assign res       = md_en_e ? '0 : alu_y;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_m      <= 1'b0;
      regwrite_m   <= 1'b0;
      memwrite_m   <= 1'b0;
      result_src_m <= '0;
      alu_result_m <= '0;
      writedata_m  <= '0;
      pc_plus_4_m  <= '0;
      rd_m         <= '0;
    end else if (flush_e | stall_e) begin
      valid_m    <= 1'b0;
      regwrite_m <= 1'b0;
      memwrite_m <= 1'b0;
    end else begin
      valid_m      <= valid_e;
      regwrite_m   <= valid_e & regwrite_e;
      memwrite_m   <= valid_e & memwrite_e;
      result_src_m <= result_src_e;
      alu_result_m <= res;
      writedata_m  <= fb;
      pc_plus_4_m  <= pc_plus_4_e;
      rd_m         <= rd_e;
    end
  end
endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: random + directed scoreboard bench for ex_stage_md.
// Expected EX/MEM results come from a plain-arithmetic reference model.
module tb_ex_stage_md;
  localparam int XLEN = 32;
  localparam int RA_W = 5;
`ifdef MD_UNIT_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  typedef struct {
    bit        valid, regwrite, memwrite, jump, branch, jalr, alu_src, md_en;
    bit [1:0]  result_src, fwd_a, fwd_b;
    bit [3:0]  alu_ctl;
    bit [2:0]  br_ctl, md_op;
    bit [31:0] rs1, rs2, pc, imm, rw;
    bit [4:0]  rd;
  } instr_t;

  typedef struct {
    bit        regw, memw;
    bit [1:0]  rsrc;
    bit [31:0] alu, wd, pc4;
    bit [4:0]  rd;
  } exp_t;

  logic            clk, reset;
  logic            valid_e, regwrite_e, memwrite_e, jump_e, branch_e;
  logic            jalr_e, alu_src_e, md_en_e, flush_e;
  logic [1:0]      result_src_e, forward_a_e, forward_b_e;
  logic [3:0]      alu_control_e;
  logic [2:0]      branch_control_e, md_op_e;
  logic [XLEN-1:0] rs1_data_e, rs2_data_e, pc_e, pc_plus_4_e;
  logic [XLEN-1:0] immediate_e, result_w;
  logic [RA_W-1:0] rd_e;
  logic            stall_e, pc_src_e, valid_m, regwrite_m, memwrite_m;
  logic [XLEN-1:0] pc_target_e, alu_result_m, writedata_m, pc_plus_4_m;
  logic [1:0]      result_src_m;
  logic [RA_W-1:0] rd_m;

  int        checks = 0;
  int        failures = 0;
  exp_t      exp_q[$];
  bit [31:0] last_alu = 0;

  ex_stage_md #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset), .valid_e(valid_e),
    .regwrite_e(regwrite_e), .memwrite_e(memwrite_e),
    .jump_e(jump_e), .branch_e(branch_e), .jalr_e(jalr_e),
    .alu_src_e(alu_src_e), .result_src_e(result_src_e),
    .alu_control_e(alu_control_e), .branch_control_e(branch_control_e),
    .md_en_e(md_en_e), .md_op_e(md_op_e),
    .rs1_data_e(rs1_data_e), .rs2_data_e(rs2_data_e),
    .pc_e(pc_e), .pc_plus_4_e(pc_plus_4_e), .immediate_e(immediate_e),
    .rd_e(rd_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .result_w(result_w), .flush_e(flush_e), .stall_e(stall_e),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .valid_m(valid_m), .regwrite_m(regwrite_m), .memwrite_m(memwrite_m),
    .result_src_m(result_src_m), .alu_result_m(alu_result_m),
    .writedata_m(writedata_m), .pc_plus_4_m(pc_plus_4_m), .rd_m(rd_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit [31:0] fwd(bit [1:0] c, bit [31:0] rf,
                                    bit [31:0] w, bit [31:0] m);
    case (c)
      2'b01:   return w;
      2'b10:   return m;
      default: return rf;
    endcase
  endfunction

  function automatic bit [31:0] alu_ref(bit [3:0] c, bit [31:0] a, bit [31:0] b);
    int sh = int'(b[4:0]);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << sh;
      4'd8:    return a >> sh;
      4'd9:    return int'(a) >>> sh;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit br_ref(bit [2:0] c, bit [31:0] a, bit [31:0] b);
    case (c)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return int'(a) < int'(b);
      3'b101:  return int'(a) >= int'(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_special(bit [2:0] op, bit [31:0] a, bit [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hffff_ffff));
  endfunction

  function automatic bit [31:0] md_ref(bit [2:0] op, bit [31:0] a, bit [31:0] b);
    longint    sa = longint'(int'(a));
    longint    sb = longint'(int'(b));
    longint    ua = longint'({32'd0, a});
    longint    ub = longint'({32'd0, b});
    bit [63:0] p;
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hffff_ffff;
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) return a;
        return int'(a) / int'(b);
      end
      3'd5: return (b == 0) ? 32'hffff_ffff : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) return 32'd0;
        return int'(a) % int'(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic drive(input instr_t t);
    valid_e          = t.valid;
    regwrite_e       = t.regwrite;
    memwrite_e       = t.memwrite;
    jump_e           = t.jump;
    branch_e         = t.branch;
    jalr_e           = t.jalr;
    alu_src_e        = t.alu_src;
    md_en_e          = t.md_en;
    result_src_e     = t.result_src;
    forward_a_e      = t.fwd_a;
    forward_b_e      = t.fwd_b;
    alu_control_e    = t.alu_ctl;
    branch_control_e = t.br_ctl;
    md_op_e          = t.md_op;
    rs1_data_e       = t.rs1;
    rs2_data_e       = t.rs2;
    pc_e             = t.pc;
    pc_plus_4_e      = t.pc + 32'd4;
    immediate_e      = t.imm;
    result_w         = t.rw;
    rd_e             = t.rd;
  endtask

  // Present one instruction just after a clock edge and hold it while stalled.
  task automatic run(input instr_t t, input int flush_at, input int reset_at);
    bit [31:0] fa, fb, res, tgt;
    bit        pcs, stopped;
    int        n, exp_stall;
    exp_t      e;
    drive(t);
    flush_e = 1'b0;
    fa  = fwd(t.fwd_a, t.rs1, t.rw, last_alu);
    fb  = fwd(t.fwd_b, t.rs2, t.rw, last_alu);
    res = t.md_en ? (MD ? md_ref(t.md_op, fa, fb) : 32'd0)
                  : alu_ref(t.alu_ctl, fa, t.alu_src ? t.imm : fb);
    exp_stall = (MD && t.valid && t.md_en)
              ? (is_special(t.md_op, fa, fb) ? 1 : XLEN + 1) : 0;
    pcs = t.valid && (t.jump || (t.branch && br_ref(t.br_ctl, fa, fb)));
    tgt = t.jalr ? ((fa + t.imm) & ~32'd1) : t.pc + t.imm;
    @(negedge clk);
    chk("pc_src", pc_src_e, pcs);
    chk("pc_target", pc_target_e, tgt);
    n = 0;
    stopped = 1'b0;
    while (!stopped && n < 200) begin
      if (n == flush_at) begin
        #2 flush_e = 1'b1;
        #1;
        chk("flush_stall", stall_e, 1'b0);
        chk("flush_pc_src", pc_src_e, 1'b0);
        @(posedge clk);
        #1;
        chk("flush_bubble", {valid_m, regwrite_m, memwrite_m}, 3'b000);
        flush_e  = 1'b0;
        result_w = t.rw;
        return;
      end
      if (n == reset_at) begin
        #2 reset = 1'b1;
        valid_e = 1'b0;
        #1;
        chk("reset_async", {valid_m, regwrite_m, memwrite_m, result_src_m,
            alu_result_m, writedata_m, pc_plus_4_m, rd_m, stall_e, pc_src_e}, '0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        result_w = t.rw;
        last_alu = 32'd0;
        return;
      end
      if (!stall_e) stopped = 1'b1;
      else begin
        n++;
        if (n >= 2) result_w = $urandom;
        @(negedge clk);
      end
    end
    result_w = t.rw;
    chk("stall_cycles", n, exp_stall);
    if (t.valid) begin
      e.regw = t.regwrite;
      e.memw = t.memwrite;
      e.rsrc = t.result_src;
      e.alu  = res;
      e.wd   = fb;
      e.pc4  = t.pc + 32'd4;
      e.rd   = t.rd;
      exp_q.push_back(e);
    end
    last_alu = res;
    @(posedge clk);
    #1;
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      if (valid_m) begin
        chk("queue_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("alu_result_m", alu_result_m, e.alu);
          chk("exmem_fields",
              {regwrite_m, memwrite_m, result_src_m, writedata_m, pc_plus_4_m, rd_m},
              {e.regw, e.memw, e.rsrc, e.wd, e.pc4, e.rd});
        end
      end else begin
        chk("bubble_ctrl", {regwrite_m, memwrite_m}, 2'b00);
      end
    end
  end

  function automatic instr_t base();
    instr_t t = '{default: 0};
    t.valid    = 1'b1;
    t.regwrite = 1'b1;
    t.rd       = 5'd3;
    t.pc       = 32'h40;
    return t;
  endfunction

  function automatic instr_t mdi(bit [2:0] op, bit [31:0] a, bit [31:0] b);
    instr_t t = base();
    t.md_en = 1'b1;
    t.md_op = op;
    t.rs1   = a;
    t.rs2   = b;
    return t;
  endfunction

  function automatic bit [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hffff_ffff;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      4:       return 32'd0 - $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  function automatic instr_t rnd_instr();
    instr_t t;
    t.valid      = $urandom_range(0, 7) != 0;
    t.regwrite   = 1'($urandom);
    t.memwrite   = 1'($urandom);
    t.md_en      = t.valid && $urandom_range(0, 3) == 0;
    t.jump       = !t.md_en && $urandom_range(0, 5) == 0;
    t.jalr       = t.jump && 1'($urandom);
    t.branch     = !t.md_en && !t.jump && $urandom_range(0, 2) == 0;
    t.alu_src    = 1'($urandom);
    t.result_src = 2'($urandom);
    t.fwd_a      = 2'($urandom);
    t.fwd_b      = 2'($urandom);
    t.alu_ctl    = 4'($urandom_range(0, 11));
    t.br_ctl     = 3'($urandom);
    t.md_op      = 3'($urandom);
    t.rs1        = rnd_val();
    t.rs2        = rnd_val();
    t.rw         = rnd_val();
    t.imm        = $urandom_range(0, 1) != 0 ? rnd_val() : $urandom_range(0, 31);
    t.pc         = $urandom & 32'hffff_fffc;
    t.rd         = 5'($urandom);
    return t;
  endfunction

  initial begin
    instr_t t;
    reset = 1'b1;
    t = '{default: 0};
    drive(t);
    flush_e = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {valid_m, regwrite_m, memwrite_m, result_src_m,
        alu_result_m, writedata_m, pc_plus_4_m, rd_m, stall_e, pc_src_e}, '0);
    @(posedge clk);
    #1 reset = 1'b0;

    t = base(); t.alu_src = 1'b1; t.rs1 = 32'd5;
    run(t, -1, -1);
    t = base(); t.fwd_a = 2'b10; t.rs2 = 32'd7;
    run(t, -1, -1);
    t = base(); t.branch = 1'b1; t.rs1 = 32'd3; t.rs2 = 32'd3;
    t.alu_src = 1'b1; t.imm = 32'd16; t.pc = 32'h100;
    run(t, -1, -1);
    t = base(); t.jump = 1'b1; t.jalr = 1'b1; t.alu_src = 1'b1; t.rs1 = 32'h203;
    run(t, -1, -1);
    t = base(); t.valid = 1'b0; t.alu_src = 1'b1; t.rs1 = 32'd40; t.imm = 32'd2;
    run(t, -1, -1);
    t = base(); t.fwd_a = 2'b10; t.rs2 = 32'd1;
    run(t, -1, -1);

    run(mdi(3'd4, 32'hffff_fff9, 32'd2), -1, -1);
    run(mdi(3'd6, 32'hffff_fff9, 32'd2), -1, -1);
    run(mdi(3'd3, 32'hffff_ffff, 32'hffff_ffff), -1, -1);
    run(mdi(3'd5, 32'd1234, 32'd0), -1, -1);
    run(mdi(3'd4, 32'h8000_0000, 32'hffff_ffff), -1, -1);
    run(mdi(3'd6, 32'h8000_0000, 32'hffff_ffff), -1, -1);
    t = mdi(3'd1, 32'h8000_0000, 32'd3); t.fwd_b = 2'b01; t.rw = 32'd7;
    run(t, -1, -1);
    t = mdi(3'd2, 32'hffff_fffe, 32'hffff_ffff); t.fwd_a = 2'b10;
    run(t, -1, -1);

    run(mdi(3'd0, 32'd100, 32'd7), MD ? 10 : 0, -1);
    t = base(); t.fwd_a = 2'b10; t.alu_src = 1'b1; t.imm = 32'd9;
    run(t, -1, -1);
    run(mdi(3'd7, 32'd100, 32'd7), -1, -1);
    run(mdi(3'd4, 32'd1000, 32'd9), -1, MD ? 10 : 0);
    run(mdi(3'd6, 32'd1000, 32'hffff_fff7), -1, -1);

    for (int i = 0; i < 300; i++) begin
      t = rnd_instr();
      if ($urandom_range(0, 15) == 0)
        run(t, (MD && t.md_en) ? int'($urandom_range(0, 20)) : 0, -1);
      else
        run(t, -1, -1);
    end

    t = '{default: 0};
    drive(t);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
